frame_generator_impl: RTL

Transmit-side counterpart of the per-port test-frame checker. It generates IPv4 test frames with the test protocol and TOS values, a correct header checksum, and LFSR-derived payload. Frames go out as a 512-bit AXIS stream toward the port's TX path. Each port's generator is started and stopped by the tester controller, which reads back sent-frame and sent-byte counters.

---
 rtl/frame_generator_impl_pkg.sv | 82 ++++++++
 rtl/frame_generator_impl_lfsr.sv | 38 +++
 rtl/frame_generator_impl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_generator_impl_pkg.sv
// Shared types, constants and helpers for the test-frame generator.
//   gen_config_t   : run configuration latched on start
//   gen_result_t   : sent-frame / sent-byte counters reported to the controller
//   frame_header_t : Ethernet + IPv4 header (34 bytes, network order, byte 0 in MSBs)
//   lfsr_step      : one step of the 16-bit payload/id LFSR
//   clamp_len      : frame length clamped to the legal 60..1514 byte range
//   ip_header_checksum : IPv4 header checksum over 20 header bytes (checksum field = 0)
package frame_generator_impl_pkg;

   localparam logic [10:0] MIN_FRAME_LEN    = 11'd60;
   localparam logic [10:0] MAX_FRAME_LEN    = 11'd1514;
   localparam logic [15:0] DEFAULT_SEED     = 16'hACE1;
   localparam logic [7:0]  TEST_FRAME_PROTO = 8'hFD;
   localparam logic [7:0]  TEST_FRAME_TOS   = 8'h28;
   localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
   localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
   localparam logic [7:0]  IPV4_TTL         = 8'd64;
   localparam int          HEADER_BYTES     = 34;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [10:0] frame_len;
      logic [15:0] seed;
      logic [31:0] frame_count;
      logic [7:0]  gap;
   } gen_config_t;

   typedef struct packed {
      logic [31:0] sent_frames;
      logic [63:0] sent_bytes;
   } gen_result_t;

   // The low 160 bits of this struct are exactly the 20-byte IPv4 header.
   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ether_type;
      logic [7:0]  ver_ihl;
      logic [7:0]  tos;
      logic [15:0] total_length;
      logic [15:0] ip_id;
      logic [15:0] flags_frag;
      logic [7:0]  ttl;
      logic [7:0]  proto;
      logic [15:0] checksum;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
   } frame_header_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEAD,
      ST_BODY,
      ST_GAP
   } gen_state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [10:0] clamp_len(input logic [10:0] len);
      if (len < MIN_FRAME_LEN) return MIN_FRAME_LEN;
      if (len > MAX_FRAME_LEN) return MAX_FRAME_LEN;
      return len;
   endfunction

   function automatic logic [15:0] ip_header_checksum(input logic [159:0] hdr);
      logic [19:0] sum;
      sum = '0;
      for (int i = 0; i < 10; i++) begin
         sum = sum + {4'd0, hdr[159-16*i -: 16]};
      end
      // Two end-around-carry folds are enough for ten 16-bit words.
      sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
      sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
      return ~sum[15:0];
   endfunction

endpackage

// File: rtl/frame_generator_impl_lfsr.sv
// 16-bit payload LFSR.
//   load/load_value : reload the register (takes priority over advance)
//   advance         : step the register once
//   next_value      : step() of the current register value (combinational)
module frame_generator_impl_lfsr16
   import frame_generator_impl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        advance,
   output logic [15:0] next_value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   assign next_value = lfsr_step(value_q);

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_value;
      end else if (advance) begin
         value_d = next_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= DEFAULT_SEED;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/frame_generator_impl.sv
// IPv4 test-frame generator producing a 64-byte-per-beat AXIS stream.
//   clk, rst        : clock, synchronous active-high reset
//   ready           : idle and able to accept start
//   start, stop     : one-cycle control pulses from the tester controller
//   config_in       : run configuration (named config_in since config is a reserved word)
//   result          : saturating sent-frame / sent-byte counters
//   axis_m_*        : AXIS master; user is always 0, id is always PORT_ID
module frame_generator_impl
   import frame_generator_impl_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 3,
   parameter int PORT_ID    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    start,
   input  logic                    stop,
   input  gen_config_t             config_in,
   output gen_result_t             result,
   output logic [DATA_WIDTH-1:0]   axis_m_data,
   output logic [DATA_WIDTH/8-1:0] axis_m_keep,
   output logic                    axis_m_last,
   output logic [DATA_WIDTH/8-1:0] axis_m_user,
   output logic [ID_WIDTH-1:0]     axis_m_id,
   output logic                    axis_m_valid,
   input  logic                    axis_m_ready
);

   localparam int KEEP_W = DATA_WIDTH / 8;

   gen_state_t            state_q, state_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [KEEP_W-1:0]     keep_q, keep_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ready_q, ready_d;
   gen_result_t           result_q, result_d;
   gen_config_t           cfg_q, cfg_d;
   logic [15:0]           id_q, id_d;
   logic [4:0]            beat_k_q, beat_k_d;
   logic [7:0]            gap_cnt_q, gap_cnt_d;
   logic                  stop_q, stop_d;

   // Beat builder: describes the beat that will be loaded next, if the FSM takes it.
   gen_config_t           b_cfg;
   logic [15:0]           b_id;
   logic [15:0]           b_v;
   logic [4:0]            b_k;
   logic [10:0]           b_len;
   logic [10:0]           b_len_m1;
   logic [6:0]            b_last_bytes;
   logic                  b_is_last;
   frame_header_t         b_hdr_nocs;
   frame_header_t         b_hdr;
   logic [DATA_WIDTH-1:0] b_data;
   logic [KEEP_W-1:0]     b_keep;

   logic [15:0]           lfsr_next;
   logic                  lfsr_load;
   logic                  lfsr_advance;

   logic                  unused_cfg_bits;
   assign unused_cfg_bits = ^{b_cfg.seed, b_cfg.frame_count, b_cfg.gap};

   frame_generator_impl_lfsr16 u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .load       (lfsr_load),
      .load_value (b_v),
      .advance    (lfsr_advance),
      .next_value (lfsr_next)
   );

   // Builder inputs depend only on registered state, so the FSM can pick the
   // result without a combinational loop. Default: first beat of the next frame.
   always_comb begin
      b_cfg = cfg_q;
      b_id  = lfsr_step(id_q);
      b_k   = '0;
      b_v   = lfsr_step(id_q);
      unique case (state_q)
         ST_IDLE: begin
            b_cfg = config_in;
            b_id  = (config_in.seed == 16'd0) ? DEFAULT_SEED : config_in.seed;
            b_v   = (config_in.seed == 16'd0) ? DEFAULT_SEED : config_in.seed;
         end
         ST_HEAD, ST_BODY: begin
            if (!last_q) begin
               b_id = id_q;
               b_k  = beat_k_q + 5'd1;
               b_v  = lfsr_next;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      b_len        = clamp_len(b_cfg.frame_len);
      b_len_m1     = b_len - 11'd1;
      b_is_last    = (b_k == b_len_m1[10:6]);
      b_last_bytes = (b_len[5:0] == 6'd0) ? 7'd64 : {1'b0, b_len[5:0]};

      b_hdr_nocs              = '0;
      b_hdr_nocs.dst_mac      = b_cfg.dst_mac;
      b_hdr_nocs.src_mac      = b_cfg.src_mac;
      b_hdr_nocs.ether_type   = ETHERTYPE_IPV4;
      b_hdr_nocs.ver_ihl      = IPV4_VER_IHL;
      b_hdr_nocs.tos          = TEST_FRAME_TOS;
      b_hdr_nocs.total_length = {5'd0, b_len} - 16'd14;
      b_hdr_nocs.ip_id        = b_id;
      b_hdr_nocs.flags_frag   = 16'd0;
      b_hdr_nocs.ttl          = IPV4_TTL;
      b_hdr_nocs.proto        = TEST_FRAME_PROTO;
      b_hdr_nocs.checksum     = 16'd0;
      b_hdr_nocs.src_ip       = b_cfg.src_ip;
      b_hdr_nocs.dst_ip       = b_cfg.dst_ip;

      b_hdr          = b_hdr_nocs;
      b_hdr.checksum = ip_header_checksum(b_hdr_nocs[159:0]);
   end

   for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_byte
      logic [7:0] pay_byte;
      logic [7:0] raw_byte;
      if ((gi % 2) == 0) begin : g_even
         assign pay_byte = b_v[7:0];
      end else begin : g_odd
         assign pay_byte = b_v[15:8];
      end
      if (gi < HEADER_BYTES) begin : g_hdr
         assign raw_byte = (b_k == 5'd0) ? b_hdr[$bits(frame_header_t)-1-8*gi -: 8] : pay_byte;
      end else begin : g_pay
         assign raw_byte = pay_byte;
      end
      assign b_keep[gi]          = !b_is_last || (7'(gi) < b_last_bytes);
      assign b_data[8*gi +: 8]   = b_keep[gi] ? raw_byte : 8'd0;
   end

   logic [10:0] cur_len;
   logic [32:0] frames_sum;
   logic [64:0] bytes_sum;
   logic [31:0] frames_sat;
   logic        handshake;
   logic        load_beat;
   logic        clear_beat;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      last_d       = last_q;
      keep_d       = keep_q;
      data_d       = data_q;
      result_d     = result_q;
      cfg_d        = cfg_q;
      id_d         = id_q;
      beat_k_d     = beat_k_q;
      gap_cnt_d    = gap_cnt_q;
      stop_d       = stop_q | stop;
      lfsr_load    = 1'b0;
      lfsr_advance = 1'b0;
      load_beat    = 1'b0;
      clear_beat   = 1'b0;
      handshake    = valid_q & axis_m_ready;
      cur_len      = clamp_len(cfg_q.frame_len);
      frames_sum   = {1'b0, result_q.sent_frames} + 33'd1;
      bytes_sum    = {1'b0, result_q.sent_bytes} + {54'd0, cur_len};
      frames_sat   = frames_sum[32] ? '1 : frames_sum[31:0];

      unique case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            if (start) begin
               cfg_d     = config_in;
               result_d  = '0;
               id_d      = b_id;
               lfsr_load = 1'b1;
               load_beat = 1'b1;
               state_d   = ST_HEAD;
            end
         end
         ST_HEAD, ST_BODY: begin
            if (handshake) begin
               if (last_q) begin
                  result_d.sent_frames = frames_sat;
                  result_d.sent_bytes  = bytes_sum[64] ? '1 : bytes_sum[63:0];
                  if (stop_d || (cfg_q.frame_count != 32'd0 && frames_sat >= cfg_q.frame_count)) begin
                     state_d    = ST_IDLE;
                     clear_beat = 1'b1;
                  end else if (cfg_q.gap == 8'd0) begin
                     id_d      = b_id;
                     lfsr_load = 1'b1;
                     load_beat = 1'b1;
                     state_d   = ST_HEAD;
                  end else begin
                     gap_cnt_d  = cfg_q.gap;
                     clear_beat = 1'b1;
                     state_d    = ST_GAP;
                  end
               end else begin
                  lfsr_advance = 1'b1;
                  load_beat    = 1'b1;
                  state_d      = ST_BODY;
               end
            end
         end
         ST_GAP: begin
            if (stop_d) begin
               state_d = ST_IDLE;
            end else if (gap_cnt_q <= 8'd1) begin
               id_d      = b_id;
               lfsr_load = 1'b1;
               load_beat = 1'b1;
               state_d   = ST_HEAD;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_beat) begin
         valid_d  = 1'b1;
         data_d   = b_data;
         keep_d   = b_keep;
         last_d   = b_is_last;
         beat_k_d = b_k;
      end else if (clear_beat) begin
         valid_d = 1'b0;
         data_d  = '0;
         keep_d  = '0;
         last_d  = 1'b0;
      end

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         keep_q    <= '0;
         data_q    <= '0;
         ready_q   <= 1'b1;
         result_q  <= '0;
         cfg_q     <= '0;
         id_q      <= '0;
         beat_k_q  <= '0;
         gap_cnt_q <= '0;
         stop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         keep_q    <= keep_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
         cfg_q     <= cfg_d;
         id_q      <= id_d;
         beat_k_q  <= beat_k_d;
         gap_cnt_q <= gap_cnt_d;
         stop_q    <= stop_d;
      end
   end

   assign ready        = ready_q;
   assign result       = result_q;
   assign axis_m_data  = data_q;
   assign axis_m_keep  = keep_q;
   assign axis_m_last  = last_q;
   assign axis_m_valid = valid_q;
   assign axis_m_user  = '0;
   assign axis_m_id    = ID_WIDTH'(PORT_ID);

endmodule
